// File: rtl/seq_bit_frontend.sv
// Step-button bit entry front end: synchronizes din/btn and debounces btn.
// Each accepted press strobes the din value into a 4-bit history.
module seq_bit_frontend #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       btn,
  output logic       bit_valid,
  output logic       bit_out,
  output logic [3:0] hist,
  output logic [7:0] bit_count
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [1:0]    btn_sync;
  logic [1:0]    din_sync;
  logic          btn_s;
  logic          din_s;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  assign btn_s = btn_sync[1];
  assign din_s = din_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 2'b00;
      din_sync <= 2'b00;
    end else begin
      btn_sync <= {btn_sync[0], btn};
      din_sync <= {din_sync[0], din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      hist      <= 4'b0000;
      bit_count <= 8'd0;
    end else begin
      bit_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            // accept: capture din_s as sampled on this same edge
            state     <= HELD;
            bit_valid <= 1'b1;
            bit_out   <= din_s;
            hist      <= {hist[2:0], din_s};
            bit_count <= bit_count + 8'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_frontend.sv
// Directed bench for seq_bit_frontend with DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_seq_bit_frontend;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       btn;
  logic       bit_valid;
  logic       bit_out;
  logic [3:0] hist;
  logic [7:0] bit_count;

  int n_chk;
  int n_fail;
  int n_strobe;
  int s0;

  seq_bit_frontend #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .btn       (btn),
    .bit_valid (bit_valid),
    .bit_out   (bit_out),
    .hist      (hist),
    .bit_count (bit_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_strobe <= 0;
    else if (bit_valid) n_strobe <= n_strobe + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic v);
    din = v;
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(10);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    din    = 1'b0;
    btn    = 1'b0;
    tick(3);
    chk("rst_valid", 32'(bit_valid), 32'd0);
    chk("rst_bit",   32'(bit_out),   32'd0);
    chk("rst_hist",  32'(hist),      32'd0);
    chk("rst_count", 32'(bit_count), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // clean press, din=1: strobe after the 7th edge
    din = 1'b1;
    btn = 1'b1;
    tick(6);
    chk("lat_early", 32'(bit_valid), 32'd0);
    chk("lat_count_early", 32'(bit_count), 32'd0);
    tick(1);
    chk("lat_strobe", 32'(bit_valid), 32'd1);
    chk("clean_bit",  32'(bit_out),   32'd1);
    chk("clean_hist", 32'(hist),      32'b0001);
    chk("clean_cnt",  32'(bit_count), 32'd1);
    din = 1'b0;
    tick(1);
    chk("one_cycle",  32'(bit_valid), 32'd0);
    chk("bit_hold",   32'(bit_out),   32'd1);
    tick(12);
    btn = 1'b0;
    tick(10);
    chk("clean_once", 32'(n_strobe), 32'd1);

    // press bounce: never reaches the window
    s0 = n_strobe;
    din = 1'b1;
    btn = 1'b1; tick(2);
    btn = 1'b0; tick(1);
    btn = 1'b1; tick(2);
    btn = 1'b0; tick(10);
    chk("pb_strobe", 32'(n_strobe - s0), 32'd0);
    chk("pb_hist",   32'(hist),      32'b0001);
    chk("pb_cnt",    32'(bit_count), 32'd1);

    // accepted press, then release bounce
    din = 1'b0;
    btn = 1'b1;
    tick(10);
    chk("rb_first", 32'(bit_count), 32'd2);
    s0 = n_strobe;
    btn = 1'b0; tick(2);
    btn = 1'b1; tick(1);
    btn = 1'b0; tick(10);
    chk("rb_strobe", 32'(n_strobe - s0), 32'd0);
    press(1'b1);
    chk("rb_next",   32'(n_strobe - s0), 32'd1);
    chk("rb_hist",   32'(hist),      32'b0101);
    chk("rb_cnt",    32'(bit_count), 32'd3);

    // din toggled right after the sampling edge is ignored
    din = 1'b0;
    btn = 1'b1;
    tick(6);
    din = 1'b1;
    tick(1);
    chk("din_edge_bit", 32'(bit_out), 32'd0);
    din = 1'b0;
    tick(3);
    btn = 1'b0;
    tick(10);
    chk("din_edge_hist", 32'(hist), 32'b1010);

    // pattern 1,0,1,1
    press(1'b1);
    press(1'b0);
    press(1'b1);
    press(1'b1);
    chk("pat_hist", 32'(hist),      32'b1011);
    chk("pat_cnt",  32'(bit_count), 32'd8);

    // wrap: 248 more presses reach 256 -> 0
    for (int i = 0; i < 248; i++) press(1'b0);
    chk("wrap_zero", 32'(bit_count), 32'd0);
    for (int i = 0; i < 8; i++) press(1'b1);
    chk("wrap_cnt",  32'(bit_count), 32'd8);
    chk("wrap_hist", 32'(hist),      32'b1111);

    // async reset in PRESS_WAIT with cnt=2
    s0 = n_strobe;
    btn = 1'b1;
    tick(5);
    btn = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bit_valid), 32'd0);
    chk("ar_bit",   32'(bit_out),   32'd0);
    chk("ar_hist",  32'(hist),      32'd0);
    chk("ar_cnt",   32'(bit_count), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(15);
    chk("ar_nostrobe", 32'(n_strobe), 32'd0);

    // reset with btn held high: synchronizers refill, strobe D+3 edges later
    btn = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("rr_early", 32'(bit_valid), 32'd0);
    tick(1);
    chk("rr_strobe", 32'(bit_valid), 32'd1);
    chk("rr_cnt",    32'(bit_count), 32'd1);
    btn = 1'b0;
    tick(10);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
